uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Parametrised UART receiver; next generation of the start-bit detector. Full frame
//  reception on one clock: oversampled start-bit validation, 5..9 data bits (LSB first),
//  optional parity, 1 or 2 stop bits. Result goes to a one-entry valid/ready holding register
//  with error flags. Sits between the baud generator (tick enable) and the RX FIFO or consumer.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, legal 5..9
//  SAMPLE_RATE  16  baud_tick pulses per bit period, even, >=4
//  PARITY_EN    0   1 = one parity bit follows the data bits
//  PARITY_ODD   0   0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//  STOP_BITS    1   1 or 2
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst_n       in   1          asynchronous reset, active low
//  baud_tick   in   1          1-clk enable, SAMPLE_RATE pulses per bit
//  rx          in   1          asynchronous serial line, idle high
//  rx_data     out  DATA_BITS  received word, valid while rx_valid=1
//  rx_valid    out  1          holding register full
//  rx_ready    in   1          consumer accepts when rx_valid & rx_ready
//  parity_err  out  1          qualifies rx_data; parity mismatch
//  frame_err   out  1          qualifies rx_data; a stop bit sampled 0
//  rx_break    out  1          qualifies rx_data; frame_err with all data and parity bits 0
//  overrun     out  1          1-clk pulse; a completed frame was dropped
//  rx_busy     out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; counters=0; synchroniser=1; outputs all 0.
//  rx passes a 2-flop synchroniser. All sampling uses the synchronised value, only on baud_tick.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: on a tick with rx=0, go to START with tick_cnt=0.
//   START: count ticks. When tick_cnt reaches SAMPLE_RATE/2-1, sample (mid start bit).
//    If 1: glitch; return to IDLE with no output. If 0: go to DATA with tick_cnt=0, bit_cnt=0.
//   DATA: sample when tick_cnt==SAMPLE_RATE-1 (mid bit), then tick_cnt=0. Shift in LSB first.
//    After DATA_BITS samples go to PARITY if PARITY_EN, else to STOP.
//   PARITY: one mid-bit sample. err = (^data ^ pbit) != PARITY_ODD.
//   STOP: STOP_BITS mid-bit samples. Any 0 sets frame_err.
//    After the last stop sample, return to IDLE immediately (half bit early; allows resync).
//  Completion: completion happens on the clk edge of the last stop sample.
//   On the next edge: rx_data and the flags load, and rx_valid=1. Latency is 1 clk after that tick.
//  Handshake: rx_valid stays high until the rx_valid&rx_ready edge.
//   Data and flags hold stable while rx_valid=1.
//  Simultaneous events: completion in the same cycle as the accept loads the new frame, and
//   rx_valid stays 1. Completion while full and not accepted drops the new frame, keeps the old
//   one, and pulses overrun.
//  New start detection continues regardless of holding-register state.
//  Line held low: it yields a break frame. FSM then waits in IDLE until rx returns 1 before
//   re-arming (no back-to-back break frames).
//  Counter widths: tick_cnt $clog2(SAMPLE_RATE); bit_cnt $clog2(DATA_BITS+1). No wrap in use.
//  baud_tick with rx_ready toggling mid-frame has no effect on reception.
// STRUCTURE
//  uart_defs.vh (shared with TX): FSM state localparams (IDLE=0,START=1,DATA=2,PARITY=3,
//   STOP=4), parity mode constants, default SAMPLE_RATE.
//  Sub-module uart_rx_sync: 2-flop synchroniser with async reset to 1.
//  Instantiated once here, reused by the TX CTS input.
// TESTING (SAMPLE_RATE=16, baud_tick every 4 clk unless stated)
//  8N1, send 0xA5 -> rx_data=0xA5, rx_valid rises 1 clk after mid stop-bit tick, no error flags.
//  Start glitch: rx low for 5 ticks, then high -> rx_busy pulses, returns to IDLE, rx_valid stays 0.
//  8E1 (PARITY_EN=1), send 0x03 with parity bit 1 -> parity_err=1, rx_data=0x03.
//  Same frame with parity bit 0 -> parity_err=0.
//  Stop bit forced 0 on 0x5A -> frame_err=1, rx_break=0.
//  rx held low 2 frames -> one frame, 0x00 with frame_err=1 and rx_break=1; nothing more until rx=1.
//  rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun 1-clk pulse.
//  Then rx_ready=1 -> rx_valid falls.
//  Accept on the exact completion clk of 0x33 -> rx_valid stays 1, rx_data=0x33, no overrun.
//  rst_n low mid DATA bit 3 -> all outputs 0 immediately.
//  After release, a full 0xC3 frame is received correctly.
//  DATA_BITS=9, STOP_BITS=2, send 0x1FF -> rx_data=0x1FF.
//  Second stop bit 0 -> frame_err=1.

Source files
------------

// File: rtl/uart_rx_oversampled_pkg.sv
// Shared definitions for the oversampled UART receiver.
//   rx_state_e          receiver FSM state encoding (IDLE=0 .. STOP=4)
//   PARITY_MODE_*       parity mode selectors for the PARITY_ODD parameter
//   DEFAULT_SAMPLE_RATE baud_tick pulses per bit period when not overridden
//   parity_error()      parity check over the data-bit XOR and the received parity bit
package uart_rx_oversampled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_MODE_EVEN    = 0;
  localparam int PARITY_MODE_ODD     = 1;
  localparam int DEFAULT_SAMPLE_RATE = 16;

  // Even parity: data bits plus parity bit must XOR to 0. Odd parity: to 1.
  function automatic logic parity_error(input logic data_xor, input logic pbit, input int mode);
    return (data_xor ^ pbit) != (mode == PARITY_MODE_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Both flops reset to 1 so that leaving reset never looks like a start bit.
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   din    in  asynchronous input
//   dout   out synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with a one-entry valid/ready holding register.
// Receives start bit, DATA_BITS data bits (LSB first), optional parity and
// STOP_BITS stop bits. All sampling uses the synchronised line and happens
// only on baud_tick, at the middle of each bit.
// Parameters: DATA_BITS 5..9, SAMPLE_RATE even and >=4, PARITY_EN 0/1,
//             PARITY_ODD 0 even / 1 odd, STOP_BITS 1 or 2.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   baud_tick   in   1-clk enable, SAMPLE_RATE pulses per bit
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  received word, valid while rx_valid=1
//   rx_valid    out  holding register full
//   rx_ready    in   consumer accepts when rx_valid & rx_ready
//   parity_err  out  parity mismatch on the held word
//   frame_err   out  a stop bit of the held word sampled 0
//   rx_break    out  frame_err with all data and parity bits 0
//   overrun     out  1-clk pulse, a completed frame was dropped
//   rx_busy     out  FSM not in IDLE
// The FSM state is visible as the internal signal 'state' (rx_state_e).
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = PARITY_MODE_EVEN,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_break,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rx_s;

  rx_state_e            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 pbit_q, pbit_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 brk_q, brk_n;
  logic                 armed_q, armed_n;
  logic                 done_q, done_n;
  logic                 ferr_final;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx),
    .dout  (rx_s)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM: next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    pbit_n     = pbit_q;
    perr_n     = perr_q;
    ferr_n     = ferr_q;
    brk_n      = brk_q;
    armed_n    = armed_q;
    done_n     = 1'b0;
    ferr_final = ferr_q | ~rx_s;

    // After a break the line may still be low; a high line re-arms start detection.
    if (rx_s) armed_n = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (baud_tick && armed_q && !rx_s) begin
          state_n    = ST_START;
          tick_cnt_n = '0;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_HALF) begin
            if (rx_s) begin
              // Line went back high before mid start bit: glitch, no frame.
              state_n = ST_IDLE;
            end else begin
              state_n    = ST_DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
              pbit_n     = 1'b0;
              perr_n     = 1'b0;
              ferr_n     = 1'b0;
              brk_n      = 1'b0;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            // LSB arrives first and ends up in bit 0 after DATA_BITS shifts.
            shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_n = '0;
              state_n   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            pbit_n     = rx_s;
            perr_n     = parity_error(^shift_q, rx_s, PARITY_ODD);
            state_n    = ST_STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            ferr_n     = ferr_final;
            if (bit_cnt == STOP_LAST) begin
              // Leave half a bit early so the next start edge is caught in time.
              bit_cnt_n = '0;
              state_n   = ST_IDLE;
              done_n    = 1'b1;
              brk_n     = ferr_final && (shift_q == '0) && !pbit_q;
              if (ferr_final && (shift_q == '0) && !pbit_q) armed_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      pbit_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      armed_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift_q  <= shift_n;
      pbit_q   <= pbit_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      brk_q    <= brk_n;
      armed_q  <= armed_n;
      done_q   <= done_n;
    end
  end

  assign rx_busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Holding register. Valid/ready: a word transfers on every clk edge where
  // rx_valid & rx_ready; rx_valid never drops without that transfer and the
  // word and flags do not change while rx_valid=1 unless that same edge
  // transfers the old word (then the newly completed frame takes its place).
  // A frame completing while full and not being accepted is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_break   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_q;
          rx_break   <= brk_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: three instances (8N1, 8E1, 9N2) on one clock.
// Driver tasks put hand-built frames on each line and push the expected word
// ({break, frame_err, parity_err, data[8:0]}) into that instance's queue; a
// negedge monitor pops and compares whenever a word is handed over.
module tb_uart_rx_oversampled;

  localparam int CLK_HALF = 5;
  localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clk
  localparam int W        = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic baud_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;
  logic valid_c, perr_c, ferr_c, brk_c, ovr_c, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tdiv = 0;
  int frame_p0 = 0;
  bit p0_valid = 0;
  int rise_cyc_a = -1;
  logic prev_valid_a = 1'b0;
  int ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] exp_q_c[$];

  uart_rx_oversampled #(.DATA_BITS(8), .SAMPLE_RATE(16), .PARITY_EN(0), .PARITY_ODD(0),
                        .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .rx_break(brk_a), .overrun(ovr_a), .rx_busy(busy_a));

  uart_rx_oversampled #(.DATA_BITS(8), .SAMPLE_RATE(16), .PARITY_EN(1), .PARITY_ODD(0),
                        .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .rx_break(brk_b), .overrun(ovr_b), .rx_busy(busy_b));

  uart_rx_oversampled #(.DATA_BITS(9), .SAMPLE_RATE(16), .PARITY_EN(0), .PARITY_ODD(0),
                        .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_c), .rx_data(data_c),
    .rx_valid(valid_c), .rx_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c),
    .rx_break(brk_c), .overrun(ovr_c), .rx_busy(busy_c));

  // ---------------- clock / tick / reset-independent background ----------------
  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv + 1) % 4;
      baud_tick = (tdiv == 0);
    end
  end

  // Instance B's consumer toggles ready every clk, including mid-frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_b = ~ready_b;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic brk, input logic ferr, input logic perr,
                                            input logic [8:0] d);
    return {brk, ferr, perr, d};
  endfunction

  task automatic pop_check(input int inst, input logic [W-1:0] act);
    logic [W-1:0] e;
    bit have;
    have = 0;
    e = '0;
    case (inst)
      0: if (exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1; end
      1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1; end
      default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); have = 1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL out%0d unexpected word: got 0x%0h, none expected", inst, act);
    end else if (act !== e) begin
      errors++;
      $display("FAIL out%0d word {brk,ferr,perr,data}: got 0x%0h, expected 0x%0h", inst, act, e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a && !prev_valid_a) rise_cyc_a = cyc;
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (ovr_c) ovr_cnt_c++;
      if (valid_a && ready_a) pop_check(0, {brk_a, ferr_a, perr_a, 1'b0, data_a});
      if (valid_b && ready_b) pop_check(1, {brk_b, ferr_b, perr_b, 1'b0, data_b});
      if (valid_c && ready_c) pop_check(2, {brk_c, ferr_c, perr_c, data_c});
    end
    prev_valid_a = valid_a;
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Returns 1 time unit after a clk edge at which baud_tick was sampled high.
  task automatic sync_tick();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (baud_tick) break;
    end
    #1;
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic pbit, input logic stop1,
                            input logic stop2, input int nstop);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (par_en) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stop1;
    n++;
    if (nstop == 2) begin
      bits[n] = stop2;
      n++;
    end
    sync_tick();
    frame_p0 = cyc;
    p0_valid = 1;
    for (int i = 0; i < n; i++) begin
      set_rx(inst, bits[i]);
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    set_rx(inst, 1'b1);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit hit;
    bit busy_seen;

    #3;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset outputs a", int'({valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a, data_a}), 0);
    check("reset outputs b", int'({valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b, data_b}), 0);
    check("reset outputs c", int'({valid_c, perr_c, ferr_c, brk_c, ovr_c, busy_c, data_c}), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 8N1 0xA5: valid rises exactly 613 clk after the tick edge that starts the frame
    // (detect +4, mid start +32, 8 data bits +512, mid stop +64, load +1).
    exp_q_a.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h0A5));
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    check("a5 latency", rise_cyc_a - frame_p0, 613);

    // Start glitch: low for 5 ticks only.
    busy_seen = 0;
    sync_tick();
    rx_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_a) busy_seen = 1;
    end
    @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch busy pulse", int'(busy_seen), 1);
    check("glitch busy back to idle", int'(busy_a), 0);
    check("glitch no valid", int'(valid_a), 0);

    // Stop bit forced 0.
    exp_q_a.push_back(exp_word(1'b0, 1'b1, 1'b0, 9'h05A));
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b0, 1'b1, 1);

    // Line held low for two frame times: exactly one break word.
    exp_q_a.push_back(exp_word(1'b1, 1'b1, 1'b0, 9'h000));
    sync_tick();
    rx_a = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("break single word", exp_q_a.size(), 0);

    // Overrun: 0x11 held, 0x22 dropped.
    ready_a = 1'b0;
    exp_q_a.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h011));
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    check("overrun pulse count", ovr_cnt_a, 1);
    ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("valid falls after accept", int'(valid_a), 0);

    // Accept of 0x44 on the exact clk where 0x33 loads.
    ready_a = 1'b0;
    exp_q_a.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h044));
    send_frame(0, 9'h044, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    exp_q_a.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h033));
    p0_valid = 0;
    fork
      send_frame(0, 9'h033, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        hit = 0;
        for (int k = 0; k < 3000; k++) begin
          @(posedge clk);
          #1;
          if (p0_valid && cyc == frame_p0 + 612) begin
            hit = 1;
            break;
          end
        end
        check("completion clk reached", int'(hit), 1);
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        check("accept+load valid stays", int'(valid_a), 1);
        check("accept+load data", int'(data_a), 'h33);
      end
    join
    check("no overrun on accept+load", ovr_cnt_a, 1);

    // Asynchronous reset in the middle of data bit 3 while 0x33 is still held.
    p0_valid = 0;
    fork
      send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        hit = 0;
        for (int k = 0; k < 3000; k++) begin
          @(posedge clk);
          #1;
          if (p0_valid && cyc == frame_p0 + 290) begin
            hit = 1;
            break;
          end
        end
        check("mid-frame point reached", int'(hit), 1);
        check("busy before reset", int'(busy_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset mid-frame outputs",
              int'({valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a, data_a}), 0);
      end
    join
    exp_q_a.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    exp_q_a.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h0C3));
    send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1'b1, 1);

    // 8E1 on instance B.
    exp_q_b.push_back(exp_word(1'b0, 1'b0, 1'b1, 9'h003));
    send_frame(1, 9'h003, 8, 1, 1'b1, 1'b1, 1'b1, 1);
    exp_q_b.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h003));
    send_frame(1, 9'h003, 8, 1, 1'b0, 1'b1, 1'b1, 1);
    exp_q_b.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1);
    exp_q_b.push_back(exp_word(1'b0, 1'b0, 1'b1, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1);

    // 9 data bits, 2 stop bits on instance C.
    exp_q_c.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h1FF));
    send_frame(2, 9'h1FF, 9, 0, 1'b0, 1'b1, 1'b1, 2);
    exp_q_c.push_back(exp_word(1'b0, 1'b1, 1'b0, 9'h1FF));
    send_frame(2, 9'h1FF, 9, 0, 1'b0, 1'b1, 1'b0, 2);
    exp_q_c.push_back(exp_word(1'b0, 1'b0, 1'b0, 9'h0A6));
    send_frame(2, 9'h0A6, 9, 0, 1'b0, 1'b1, 1'b1, 2);

    repeat (50) @(posedge clk);
    #1;
    check("drain a", exp_q_a.size(), 0);
    check("drain b", exp_q_b.size(), 0);
    check("drain c", exp_q_c.size(), 0);
    check("no overrun b", ovr_cnt_b, 0);
    check("no overrun c", ovr_cnt_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
